seq_detect_ctrl: RTL and testbench

Programmable serial pattern-detection controller that sequences a bit-serial detector between idle, running and done phases. It holds the pattern configuration, qualifies incoming bits, flags matches, counts them, and stops itself when a programmed match threshold is reached. It sits between a register/config interface and a serial input stream, and generalises the fixed "011" Mealy detectors used elsewhere in the FSM library.

---
 rtl/seq_detect_pkg.sv | 19 +
 rtl/seq_match_core.sv | 61 ++++++
 rtl/seq_detect_ctrl.sv | 154 +++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_detect_pkg : shared types and reset constants for seq_detect_ctrl    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int         PAT_MAX_DEF = 8;
    localparam logic [2:0] RST_PATTERN = 3'b011;
    localparam int         RST_LEN     = 3;

endpackage
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_match_core : history shift register, bit counter and masked compare  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       shift_en,
    input  logic                       clear,
    input  logic                       inp,
    input  logic [PAT_MAX-1:0]         pattern,
    input  logic [$clog2(PAT_MAX):0]   len,
    output logic                       hit
);

    localparam int LEN_W = $clog2(PAT_MAX) + 1;

    logic [PAT_MAX-1:0] hist_q, hist_d, hist_shift, mask;
    logic [LEN_W-1:0]   bitcnt_q, bitcnt_d, bitcnt_inc;

    // Hit is evaluated on the history as it will look once this bit lands.
    always_comb begin
        hist_shift = {hist_q[PAT_MAX-2:0], inp};
        bitcnt_inc = (bitcnt_q == LEN_W'(PAT_MAX)) ? bitcnt_q : bitcnt_q + LEN_W'(1);
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = shift_en
              && (((hist_shift ^ pattern) & mask) == '0)
              && (bitcnt_inc >= len);
    end

    always_comb begin
        hist_d   = hist_q;
        bitcnt_d = bitcnt_q;
        if (clear) begin
            hist_d   = '0;
            bitcnt_d = '0;
        end else if (shift_en) begin
            hist_d   = hist_shift;
            bitcnt_d = bitcnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q   <= '0;
            bitcnt_q <= '0;
        end else begin
            hist_q   <= hist_d;
            bitcnt_q <= bitcnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_detect_ctrl : programmable serial pattern detector with IDLE/RUN/DONE |
// | sequencing, match counting and threshold stop.  Rev 1.0                  |
// +--------------------------------------------------------------------------+
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [PAT_MAX-1:0]         cfg_pattern,
    input  logic [$clog2(PAT_MAX):0]   cfg_len,
    input  logic [CNT_W-1:0]           cfg_thresh,
    input  logic                       cfg_overlap,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       inp,
    input  logic                       inp_vld,
    output logic                       det,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       done,
    output logic                       busy,
    output logic                       cfg_err
);

    localparam int LEN_W = $clog2(PAT_MAX) + 1;

    state_e             state_q, state_d;
    logic [PAT_MAX-1:0] cfg_pattern_q, cfg_pattern_d;
    logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
    logic [CNT_W-1:0]   cfg_thresh_q, cfg_thresh_d;
    logic               cfg_overlap_q, cfg_overlap_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d, cnt_inc;
    logic               det_q, det_d, done_q, done_d, busy_q, busy_d, cfg_err_q, cfg_err_d;

    logic start_go, len_ok, core_shift, core_clear, hit;

    // stop dominates start; no bit is consumed on a start or stop cycle.
    assign start_go   = start && !stop;
    assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
    assign core_shift = (state_q == ST_RUN) && inp_vld && !start && !stop;
    assign core_clear = start_go || (hit && !cfg_overlap_q);
    assign cnt_inc    = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + CNT_W'(1);

    seq_match_core #(
        .PAT_MAX (PAT_MAX)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (core_shift),
        .clear    (core_clear),
        .inp      (inp),
        .pattern  (cfg_pattern_q),
        .len      (cfg_len_q),
        .hit      (hit)
    );

    always_comb begin
        state_d       = state_q;
        cfg_pattern_d = cfg_pattern_q;
        cfg_len_d     = cfg_len_q;
        cfg_thresh_d  = cfg_thresh_q;
        cfg_overlap_d = cfg_overlap_q;
        match_cnt_d   = match_cnt_q;
        det_d         = 1'b0;
        done_d        = done_q;
        busy_d        = busy_q;
        cfg_err_d     = 1'b0;

        if (cfg_we) begin
            if ((state_q != ST_IDLE) || !len_ok) begin
                cfg_err_d = 1'b1;
            end else begin
                cfg_pattern_d = cfg_pattern;
                cfg_len_d     = cfg_len;
                cfg_thresh_d  = cfg_thresh;
                cfg_overlap_d = cfg_overlap;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (start) begin
                    match_cnt_d = '0;
                end else if (hit) begin
                    det_d       = 1'b1;
                    match_cnt_d = cnt_inc;
                    if ((cfg_thresh_q != '0) && (cnt_inc == cfg_thresh_q)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else if (start) begin
                    state_d     = ST_RUN;
                    match_cnt_d = '0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cfg_pattern_q <= PAT_MAX'(RST_PATTERN);
            cfg_len_q     <= LEN_W'(RST_LEN);
            cfg_thresh_q  <= '0;
            cfg_overlap_q <= 1'b1;
            match_cnt_q   <= '0;
            det_q         <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_pattern_q <= cfg_pattern_d;
            cfg_len_q     <= cfg_len_d;
            cfg_thresh_q  <= cfg_thresh_d;
            cfg_overlap_q <= cfg_overlap_d;
            match_cnt_q   <= match_cnt_d;
            det_q         <= det_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign det       = det_q;
    assign match_cnt = match_cnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_detect_ctrl : scoreboard bench for seq_detect_ctrl                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, cfg_we, cfg_overlap, start, stop, inp, inp_vld;
    logic [7:0] cfg_pattern, cfg_thresh;
    logic [3:0] cfg_len;
    logic       det, done, busy, cfg_err;
    logic [7:0] match_cnt;

    typedef struct packed {
        logic       det;
        logic       err;
        logic [7:0] cnt;
        logic       done;
        logic       busy;
    } evt_t;

    evt_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PAT_MAX(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_thresh  (cfg_thresh),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .stop        (stop),
        .inp         (inp),
        .inp_vld     (inp_vld),
        .det         (det),
        .match_cnt   (match_cnt),
        .done        (done),
        .busy        (busy),
        .cfg_err     (cfg_err)
    );

    // Monitor: every det or cfg_err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (det || cfg_err)) begin
            evt_t act;
            act = '{det: det, err: cfg_err, cnt: match_cnt, done: done, busy: busy};
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got det=%0b err=%0b cnt=%0d done=%0b busy=%0b, expected none at %0t",
                         act.det, act.err, act.cnt, act.done, act.busy, $time);
            end else begin
                evt_t exp;
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL event: got det=%0b err=%0b cnt=%0d done=%0b busy=%0b, expected det=%0b err=%0b cnt=%0d done=%0b busy=%0b at %0t",
                             act.det, act.err, act.cnt, act.done, act.busy,
                             exp.det, exp.err, exp.cnt, exp.done, exp.busy, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_evt(input logic d, input logic e, input logic [7:0] c,
                              input logic dn, input logic b);
        sb.push_back('{det: d, err: e, cnt: c, done: dn, busy: b});
    endtask

    task automatic drain(input string name);
        repeat (2) @(negedge clk);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic drive_bit(input logic b);
        inp = b; inp_vld = 1'b1;
        @(negedge clk);
        inp = 1'b0; inp_vld = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len,
                             input logic [7:0] thr, input logic ov);
        cfg_pattern = pat; cfg_len = len; cfg_thresh = thr; cfg_overlap = ov;
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
        cfg_overlap = 1'b0; start = 1'b0; stop = 1'b0; inp = 1'b0; inp_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_det", det, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", cfg_err, 0);

        // Default pattern 011, length 3, threshold 0.
        pulse_start();
        chk("start_busy", busy, 1);
        drive_bit(0); drive_bit(1);
        expect_evt(1, 0, 1, 0, 1);
        drive_bit(1);
        drain("t1_drain");
        chk("t1_cnt", match_cnt, 1);
        chk("t1_done", done, 0);
        pulse_stop();
        chk("t1_stop_busy", busy, 0);
        chk("t1_stop_cnt_held", match_cnt, 1);

        // Pattern 1010 len 4, overlapping.
        cfg_write(8'b1010, 4'd4, 8'd0, 1'b1);
        pulse_start();
        drive_bit(1); drive_bit(0); drive_bit(1);
        expect_evt(1, 0, 1, 0, 1); drive_bit(0);
        drive_bit(1);
        expect_evt(1, 0, 2, 0, 1); drive_bit(0);
        drain("t2_drain");
        chk("t2_cnt", match_cnt, 2);
        pulse_stop();

        // Same stream, non-overlapping.
        cfg_write(8'b1010, 4'd4, 8'd0, 1'b0);
        pulse_start();
        drive_bit(1); drive_bit(0); drive_bit(1);
        expect_evt(1, 0, 1, 0, 1); drive_bit(0);
        drive_bit(1); drive_bit(0);
        drain("t3_drain");
        chk("t3_cnt", match_cnt, 1);
        pulse_stop();

        // Threshold 2, pattern 1 len 1.
        cfg_write(8'b1, 4'd1, 8'd2, 1'b1);
        pulse_start();
        expect_evt(1, 0, 1, 0, 1); drive_bit(1);
        expect_evt(1, 0, 2, 1, 0); drive_bit(1);
        drive_bit(1);
        drain("t4_drain");
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_cnt", match_cnt, 2);
        pulse_start();
        chk("t4_restart_done", done, 0);
        chk("t4_restart_busy", busy, 1);
        chk("t4_restart_cnt", match_cnt, 0);
        // Rejected write while running; old config must still detect.
        expect_evt(0, 1, 0, 0, 1);
        cfg_write(8'b00, 4'd2, 8'd0, 1'b1);
        expect_evt(1, 0, 1, 0, 1); drive_bit(1);
        drain("t4_err_drain");
        pulse_stop();
        chk("t4_stop_busy", busy, 0);

        // Illegal lengths in IDLE.
        expect_evt(0, 1, 1, 0, 0);
        cfg_write(8'b0, 4'd0, 8'd0, 1'b1);
        expect_evt(0, 1, 1, 0, 0);
        cfg_write(8'b0, 4'd9, 8'd0, 1'b1);
        drain("t5_err_drain");
        pulse_start();
        expect_evt(1, 0, 1, 0, 1); drive_bit(1);
        drain("t5_drain");
        pulse_stop();

        // start and stop together from IDLE.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_cnt", match_cnt, 1);

        // Asynchronous reset mid-RUN restores default config.
        pulse_start();
        expect_evt(1, 0, 1, 0, 1); drive_bit(1);
        drain("t7_pre_drain");
        rst_n = 1'b0;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_cnt", match_cnt, 0);
        chk("t7_rst_det", det, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        drive_bit(1); drive_bit(0); drive_bit(1);
        expect_evt(1, 0, 1, 0, 1); drive_bit(1);
        drain("t7_default_drain");
        pulse_stop();

        // Pattern 111 with invalid-bit gaps, then restart from RUN.
        cfg_write(8'b111, 4'd3, 8'd0, 1'b1);
        pulse_start();
        drive_bit(1); drive_bit(1);
        inp = 1'b1; inp_vld = 1'b0;
        repeat (3) @(negedge clk);
        expect_evt(1, 0, 1, 0, 1); drive_bit(1);
        drain("t8_gap_drain");
        inp = 1'b1; inp_vld = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; inp = 1'b0; inp_vld = 1'b0;
        chk("t8_restart_cnt", match_cnt, 0);
        drive_bit(1); drive_bit(1);
        expect_evt(1, 0, 1, 0, 1); drive_bit(1);
        drain("t8_restart_drain");
        pulse_stop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
